// File: rtl/warp_xwb_pkg.sv
// Shared integer writeback types: widths, source select and result bundle.
package warp_xwb_pkg;

    localparam int REG_W = 5;
    localparam int XLEN  = 64;
    localparam int NREG  = 32;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_LU   = 2'd2
    } src_e;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  data;
    } wb_t;

endpackage

// File: rtl/warp_xwb_fifo.sv
// Small synchronous FIFO for single-cycle results.
module warp_xwb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wptr[AW-1:0]] <= push_data;
    end

    // Extra pointer bit tells full from empty when the indices match.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head  = mem[rptr[AW-1:0]];

endmodule

// File: rtl/warp_xwb.sv
// Integer writeback: ALU/LU arbitration, rd1 write port and busy scoreboard.
module warp_xwb
    import warp_xwb_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_alu_valid,
    output logic             o_alu_ready,
    input  logic [REG_W-1:0] i_alu_rd,
    input  logic [XLEN-1:0]  i_alu_data,
    input  logic             i_lu_valid,
    output logic             o_lu_ready,
    input  logic [REG_W-1:0] i_lu_rd,
    input  logic [XLEN-1:0]  i_lu_data,
    input  logic             i_issue_valid,
    input  logic [REG_W-1:0] i_issue_rd,
    output logic             o_rd1_wen,
    output logic [REG_W-1:0] o_rd1_addr,
    output logic [XLEN-1:0]  o_rd1_wdata,
    output logic [NREG-1:0]  o_busy
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    wb_t             alu_in;
    wb_t             head;
    wb_t             win;
    src_e            sel;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic [3:0]      starve;
    logic [NREG-1:0] busy_d;

    assign alu_in      = '{rd: i_alu_rd, data: i_alu_data};
    assign o_alu_ready = !full;
    assign push        = i_alu_valid && !full;
    assign pop         = (sel == SRC_ALU);
    assign o_lu_ready  = (sel == SRC_LU);

    warp_xwb_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(wb_t))
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .push      (push),
        .push_data (alu_in),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .head      (head)
    );

    // LU takes the port when the FIFO is idle or it has waited long enough.
    always_comb begin
        sel = SRC_NONE;
        win = '0;
        if (!i_rst && i_lu_valid && (empty || starve == LIMIT)) begin
            sel = SRC_LU;
            win = '{rd: i_lu_rd, data: i_lu_data};
        end else if (!i_rst && !empty) begin
            sel = SRC_ALU;
            win = head;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_lu_valid || o_lu_ready) begin
            starve <= '0;
        end else if (starve != LIMIT) begin
            starve <= starve + 4'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rd1_wen   <= 1'b0;
            o_rd1_addr  <= '0;
            o_rd1_wdata <= '0;
        end else begin
            o_rd1_wen <= (sel != SRC_NONE) && (win.rd != '0);
            if (sel != SRC_NONE) begin
                o_rd1_addr  <= win.rd;
                o_rd1_wdata <= win.data;
            end
        end
    end

    // A new issue to the same register outranks the completing write.
    always_comb begin
        busy_d = o_busy;
        for (int n = 1; n < NREG; n++) begin
            if (i_issue_valid && i_issue_rd == REG_W'(n)) begin
                busy_d[n] = 1'b1;
            end else if (sel != SRC_NONE && win.rd == REG_W'(n)) begin
                busy_d[n] = 1'b0;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_busy <= '0;
        end else begin
            o_busy <= busy_d;
        end
    end

endmodule

// File: tb/tb_warp_xwb.sv
// Directed bench for warp_xwb with hand-computed expected writebacks.
module tb_warp_xwb;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_alu_valid;
    logic        o_alu_ready;
    logic [4:0]  i_alu_rd;
    logic [63:0] i_alu_data;
    logic        i_lu_valid;
    logic        o_lu_ready;
    logic [4:0]  i_lu_rd;
    logic [63:0] i_lu_data;
    logic        i_issue_valid;
    logic [4:0]  i_issue_rd;
    logic        o_rd1_wen;
    logic [4:0]  o_rd1_addr;
    logic [63:0] o_rd1_wdata;
    logic [31:0] o_busy;

    int n_cmp = 0;
    int n_bad = 0;

    warp_xwb #(
        .DEPTH        (2),
        .STARVE_LIMIT (4)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_alu_valid   (i_alu_valid),
        .o_alu_ready   (o_alu_ready),
        .i_alu_rd      (i_alu_rd),
        .i_alu_data    (i_alu_data),
        .i_lu_valid    (i_lu_valid),
        .o_lu_ready    (o_lu_ready),
        .i_lu_rd       (i_lu_rd),
        .i_lu_data     (i_lu_data),
        .i_issue_valid (i_issue_valid),
        .i_issue_rd    (i_issue_rd),
        .o_rd1_wen     (o_rd1_wen),
        .o_rd1_addr    (o_rd1_addr),
        .o_rd1_wdata   (o_rd1_wdata),
        .o_busy        (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    logic [4:0]  s_rd [9];
    logic [63:0] s_dt [9];
    logic        ar;
    logic        lr;
    int          idx;
    logic        lu_done;
    logic [4:0]  iss [3];

    initial begin
        s_rd = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd7,
                 5'd14, 5'd15, 5'd16, 5'd17};
        s_dt = '{64'hA00, 64'hA01, 64'hA02, 64'hA03, 64'h7777,
                 64'hA04, 64'hA05, 64'hA06, 64'hA07};
        iss  = '{5'd8, 5'd10, 5'd11};

        i_rst = 1'b1;
        i_alu_valid = 1'b0;
        i_alu_rd = '0;
        i_alu_data = '0;
        i_lu_valid = 1'b1;
        i_lu_rd = 5'd3;
        i_lu_data = 64'h55;
        i_issue_valid = 1'b0;
        i_issue_rd = '0;

        // Reset state
        tick();
        tick();
        check("rst_lu_ready", o_lu_ready, 0);
        check("rst_alu_ready", o_alu_ready, 1);
        check("rst_wen", o_rd1_wen, 0);
        check("rst_addr", o_rd1_addr, 0);
        check("rst_wdata", o_rd1_wdata, 0);
        check("rst_busy", o_busy, 0);
        i_rst = 1'b0;
        i_lu_valid = 1'b0;
        tick();

        // Single ALU push with matching issue
        i_alu_valid = 1'b1;
        i_alu_rd = 5'd5;
        i_alu_data = 64'h1234;
        i_issue_valid = 1'b1;
        i_issue_rd = 5'd5;
        tick();
        i_alu_valid = 1'b0;
        i_issue_valid = 1'b0;
        check("one_wen_c1", o_rd1_wen, 0);
        check("one_busy_set", o_busy, 32'h20);
        tick();
        check("one_wen_c2", o_rd1_wen, 1);
        check("one_addr", o_rd1_addr, 5);
        check("one_wdata", o_rd1_wdata, 64'h1234);
        check("one_busy_clr", o_busy, 0);
        tick();
        check("one_wen_c3", o_rd1_wen, 0);

        // Back-to-back ALU stream
        for (int c = 0; c < 9; c++) begin
            i_alu_valid = (c < 8);
            i_alu_rd = 5'(c + 1);
            i_alu_data = 64'h100 + 64'(c);
            #1;
            if (c < 8) check("b2b_ready", o_alu_ready, 1);
            tick();
            if (c >= 1) begin
                check("b2b_wen", o_rd1_wen, 1);
                check("b2b_addr", o_rd1_addr, 5'(c));
                check("b2b_wdata", o_rd1_wdata, 64'h100 + 64'(c - 1));
            end
        end
        i_alu_valid = 1'b0;
        tick();
        check("b2b_wen_end", o_rd1_wen, 0);

        // LU starvation with ALU pushing every cycle
        idx = 0;
        lu_done = 1'b0;
        i_lu_rd = 5'd7;
        i_lu_data = 64'h7777;
        for (int c = 0; c < 10; c++) begin
            i_alu_valid = (idx < 8);
            i_alu_rd = 5'(10 + idx);
            i_alu_data = 64'hA00 + 64'(idx);
            i_lu_valid = (c >= 1) && !lu_done;
            #1;
            ar = o_alu_ready;
            lr = o_lu_ready;
            check("stv_lu_ready", lr, (c == 5));
            check("stv_alu_ready", ar, (c != 6));
            tick();
            if (i_alu_valid && ar) idx++;
            if (lr) lu_done = 1'b1;
            if (c >= 1) begin
                check("stv_wen", o_rd1_wen, 1);
                check("stv_addr", o_rd1_addr, s_rd[c-1]);
                check("stv_wdata", o_rd1_wdata, s_dt[c-1]);
            end
        end
        i_alu_valid = 1'b0;
        i_lu_valid = 1'b0;
        tick();
        check("stv_wen_end", o_rd1_wen, 0);
        check("stv_pushed", 64'(idx), 8);

        // Result and issue to x0
        i_alu_valid = 1'b1;
        i_alu_rd = 5'd0;
        i_alu_data = 64'hFFFF;
        i_issue_valid = 1'b1;
        i_issue_rd = 5'd0;
        tick();
        i_alu_valid = 1'b0;
        i_issue_valid = 1'b0;
        check("x0_busy", o_busy, 0);
        tick();
        check("x0_wen", o_rd1_wen, 0);
        check("x0_addr", o_rd1_addr, 0);
        check("x0_wdata", o_rd1_wdata, 64'hFFFF);
        check("x0_ready", o_alu_ready, 1);

        // Re-issue of x9 while its write completes
        i_alu_valid = 1'b1;
        i_alu_rd = 5'd9;
        i_alu_data = 64'h99;
        i_issue_valid = 1'b1;
        i_issue_rd = 5'd9;
        tick();
        check("raw_busy_set", o_busy, 32'h200);
        i_alu_valid = 1'b0;
        tick();
        i_issue_valid = 1'b0;
        check("raw_wen", o_rd1_wen, 1);
        check("raw_addr", o_rd1_addr, 9);
        check("raw_busy_keep", o_busy, 32'h200);
        tick();
        check("raw_busy_hold", o_busy, 32'h200);
        check("raw_wen_end", o_rd1_wen, 0);

        // Fill FIFO and busy bits, then reset mid-operation
        lu_done = 1'b0;
        i_lu_rd = 5'd0;
        i_lu_data = 64'hBEEF;
        for (int c = 0; c < 6; c++) begin
            i_alu_valid = 1'b1;
            i_alu_rd = 5'(20 + c);
            i_alu_data = 64'(c);
            i_lu_valid = (c >= 1) && !lu_done;
            i_issue_valid = (c < 3);
            i_issue_rd = (c < 3) ? iss[c] : 5'd0;
            #1;
            lr = o_lu_ready;
            tick();
            if (lr) lu_done = 1'b1;
        end
        i_alu_valid = 1'b0;
        i_issue_valid = 1'b0;
        check("pre_rst_busy", o_busy, 32'hF00);
        check("pre_rst_full", o_alu_ready, 0);
        check("pre_rst_lu_done", lu_done, 1);
        i_rst = 1'b1;
        i_lu_valid = 1'b1;
        i_lu_rd = 5'd7;
        #1;
        check("mid_rst_lu_ready", o_lu_ready, 0);
        tick();
        check("mid_rst_ready", o_alu_ready, 1);
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_wen", o_rd1_wen, 0);
        check("mid_rst_addr", o_rd1_addr, 0);
        check("mid_rst_wdata", o_rd1_wdata, 0);
        i_rst = 1'b0;
        i_lu_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("post_rst_wen", o_rd1_wen, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/warp_xwb.md
# warp_xwb

Integer writeback stage: merges results from the single-cycle integer units (arithmetic/logic) and the long-latency integer unit (mul/div), then drives the integer register file's single write port (rd1). Also holds the per-register busy scoreboard that issue uses for RAW/WAW hazard checks, and a forwarding copy of each committed write. Sits between the execute units and the integer register file.

## Interface
- `DEPTH`, 2: entries in the single-cycle result FIFO; power of two, ≥2.
- `STARVE_LIMIT`, 4: consecutive cycles a pending long-latency result may be refused before it takes priority; 1..15.
- `i_clk` in 1: clock.
- `i_rst` in 1: synchronous, active-high reset.
- `i_alu_valid` in 1: single-cycle result valid.
- `o_alu_ready` out 1: FIFO can accept.
- `i_alu_rd` in 5: destination register.
- `i_alu_data` in 64: result.
- `i_lu_valid` in 1: long-latency result valid; held with data until accepted.
- `o_lu_ready` out 1: long-latency result accepted this cycle.
- `i_lu_rd` in 5: destination register.
- `i_lu_data` in 64: result.
- `i_issue_valid` in 1: instruction issued this cycle; marks `i_issue_rd` busy.
- `i_issue_rd` in 5: destination of issued instruction.
- `o_rd1_wen` out 1: register-file write enable; also the forwarding valid.
- `o_rd1_addr` out 5: write address.
- `o_rd1_wdata` out 64: write data.
- `o_busy` out 32: bit n set means xn has a write outstanding; bit 0 is always 0.

## Operation
- ALU FIFO: push when `i_alu_valid && o_alu_ready`; `o_alu_ready = !full`. A push and a pop in the same cycle are allowed, including when full (ready still reflects `!full`, with no pass-through).
- Each cycle the arbiter picks at most one source:
  - LU wins if `i_lu_valid` and (FIFO empty or starve counter == `STARVE_LIMIT`).
  - Otherwise the FIFO head wins if the FIFO is non-empty.
  - `o_lu_ready` is high exactly when LU wins. It is combinational from `i_lu_valid`, FIFO state and the counter.
- Starve counter:
  - Increments while `i_lu_valid && !o_lu_ready`, saturating at `STARVE_LIMIT`.
  - Clears on LU acceptance or when `i_lu_valid` is low.
- Output register, loaded every cycle:
  - `o_rd1_wen <= winner exists && winner rd != 0`.
  - `o_rd1_addr` and `o_rd1_wdata` take the winner's values. They are held (no update) when there is no winner.
  - A result to x0 is consumed: it is popped or its handshake completes, but no write occurs.
- Scoreboard, per bit n (n≥1), next value:
  - set if `i_issue_valid && i_issue_rd == n`;
  - else clear if the winner's rd == n;
  - else hold.
  - Set wins over a simultaneous clear (a new writer was issued). Issue to x0 is ignored.
- The scoreboard does not check that a write matches an outstanding busy bit. A clear on a non-busy register is harmless.

## Timing
- Reset values:
  - FIFO empty, so `o_alu_ready=1` after reset.
  - `o_rd1_wen=0`, `o_rd1_addr=0`, `o_rd1_wdata=0`.
  - `o_busy=0`, starve counter 0.
  - `o_lu_ready=0` while `i_rst`.
- Reset mid-operation: discards FIFO contents and all busy bits; any in-flight LU result must be squashed upstream.
- ALU latency: pushed at edge N, earliest head/winner during cycle N+1, `o_rd1_wen` high during cycle N+2 (after edge N+1).
- LU latency: accepted at edge N, `o_rd1_wen` high after edge N. The busy bit clears at the same edge that loads the output register.
- Register file commits at the edge after `o_rd1_wen`. Consumers reading the same register in that cycle must forward from `o_rd1_*`.
- Sustained throughput: one write per cycle.
- FIFO pointers use `$clog2(DEPTH)+1` bits; wrap-around is by natural overflow.

## Structure
- Shared integer package:
  - source-select encoding (NONE/ALU/LU);
  - register-address width (5);
  - XLEN (64).
- One sub-module, `warp_xwb_fifo`: parameterised sync FIFO with push/pop/full/empty/head. Arbiter, starve counter, output register and scoreboard stay in `warp_xwb`.

## Test plan
- Reset, then single ALU push (rd=5, data=0x1234) at edge 0 → `o_rd1_wen=1`, addr=5, wdata=0x1234 during cycle 2 only. `o_busy[5]` clears if it was set by issue at cycle 0.
- Back-to-back ALU pushes every cycle for 8 cycles → no ready drop, 8 consecutive writes in order, FIFO never overflows.
- LU valid (rd=7) held while ALU pushes every cycle with `STARVE_LIMIT=4` → LU accepted on the 5th cycle of waiting. The ALU FIFO fills, `o_alu_ready` drops for ≥1 cycle, and no ALU result is lost.
- ALU result to x0, data=0xFFFF → pop occurs, `o_rd1_wen` stays 0. `i_issue_rd=0` leaves `o_busy=0`.
- Issue rd=9 in the same cycle that a winner with rd=9 is selected → `o_busy[9]` stays 1 while `o_rd1_wen` writes x9.
- Assert `i_rst` with 2 FIFO entries and busy=0x0000_0F00 → next cycle FIFO empty, `o_busy=0`, `o_rd1_wen=0`, and no later writes appear.
